// File: rtl/clock_time_ctrl.sv
// 24-hour BCD timekeeper with debounced two-button set flow and a blink request for the field being set.
// Latency: one clk1 cycle from a sampled tick or debounced press to the registered outputs.
// Backpressure: none; every event is consumed on the clk1 edge where it is detected.
module clock_time_ctrl #(
   parameter int unsigned DEBOUNCE_SAMPLES = 4,
   parameter int unsigned BLINK_HALF       = 125
) (
   input  logic       clk1,
   input  logic       rst,
   input  logic       clk_1hz,
   input  logic       clk_500hz,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [1:0] hr_tens,
   output logic [3:0] hr_ones,
   output logic [2:0] min_tens,
   output logic [3:0] min_ones,
   output logic [2:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic [1:0] mode,
   output logic       blink
);

   localparam int unsigned BW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

   typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10} mode_t;

   mode_t          state_q, state_d;
   logic           c1hz_q, c1hz_d, c500_q, c500_d;
   logic [1:0]     stable_q, stable_d;          // index 0 = mode button, 1 = inc button
   logic [1:0][3:0] dcnt_q, dcnt_d;
   logic [1:0]     press;
   logic [1:0]     btn_raw;
   logic [1:0]     hr_tens_q, hr_tens_d;
   logic [3:0]     hr_ones_q, hr_ones_d;
   logic [2:0]     min_tens_q, min_tens_d, sec_tens_q, sec_tens_d;
   logic [3:0]     min_ones_q, min_ones_d, sec_ones_q, sec_ones_d;
   logic           blink_q, blink_d;
   logic [BW-1:0]  bcnt_q, bcnt_d;
   logic           tick_1hz, scan_tick, mode_press, inc_press;
   logic [7:0]     sec_r, min_r;

   // Returns {wrap, tens, ones} for a 00..59 BCD field advanced by one.
   function automatic logic [7:0] inc_mod60(input logic [2:0] t, input logic [3:0] o);
      logic [7:0] r;
      if (o != 4'd9)      r = {1'b0, t, o + 4'd1};
      else if (t != 3'd5) r = {1'b0, t + 3'd1, 4'd0};
      else                r = 8'h00 | 8'h80;
      return r;
   endfunction

   // Returns {tens, ones} for 00..23 BCD hours advanced by one.
   function automatic logic [5:0] inc_hr(input logic [1:0] t, input logic [3:0] o);
      logic [5:0] r;
      if (t == 2'd2 && o == 4'd3) r = 6'd0;
      else if (o == 4'd9)         r = {t + 2'd1, 4'd0};
      else                        r = {t, o + 4'd1};
      return r;
   endfunction

   // Rising-edge detection of the divider levels and per-button debounce.
   always_comb begin
      c1hz_d    = clk_1hz;
      c500_d    = clk_500hz;
      tick_1hz  = clk_1hz & ~c1hz_q;
      scan_tick = clk_500hz & ~c500_q;
      btn_raw   = {btn_inc, btn_mode};
      stable_d  = stable_q;
      dcnt_d    = dcnt_q;
      press     = 2'b00;
      for (int i = 0; i < 2; i++) begin
         if (scan_tick) begin
            if (btn_raw[i] != stable_q[i]) begin
               if (dcnt_q[i] == 4'(DEBOUNCE_SAMPLES - 1)) begin
                  stable_d[i] = ~stable_q[i];
                  dcnt_d[i]   = 4'd0;
                  press[i]    = btn_raw[i];   // only the 0->1 flip is a press
               end else begin
                  dcnt_d[i] = dcnt_q[i] + 4'd1;
               end
            end else begin
               dcnt_d[i] = 4'd0;
            end
         end
      end
   end

   // Mode FSM and time update; a mode press swallows a same-cycle inc press.
   always_comb begin
      mode_press = press[0];
      inc_press  = press[1] & ~press[0];
      state_d    = state_q;
      hr_tens_d  = hr_tens_q;
      hr_ones_d  = hr_ones_q;
      min_tens_d = min_tens_q;
      min_ones_d = min_ones_q;
      sec_tens_d = sec_tens_q;
      sec_ones_d = sec_ones_q;
      sec_r      = 8'd0;
      min_r      = 8'd0;
      case (state_q)
         RUN: begin
            if (mode_press) state_d = SET_HR;
            if (tick_1hz) begin
               sec_r = inc_mod60(sec_tens_q, sec_ones_q);
               {sec_tens_d, sec_ones_d} = sec_r[6:0];
               if (sec_r[7]) begin
                  min_r = inc_mod60(min_tens_q, min_ones_q);
                  {min_tens_d, min_ones_d} = min_r[6:0];
                  if (min_r[7]) {hr_tens_d, hr_ones_d} = inc_hr(hr_tens_q, hr_ones_q);
               end
            end
         end
         SET_HR: begin
            if (mode_press)     state_d = SET_MIN;
            else if (inc_press) {hr_tens_d, hr_ones_d} = inc_hr(hr_tens_q, hr_ones_q);
         end
         SET_MIN: begin
            if (mode_press) begin
               state_d    = RUN;
               sec_tens_d = 3'd0;              // fresh minute starts on leaving set mode
               sec_ones_d = 4'd0;
            end else if (inc_press) begin
               min_r = inc_mod60(min_tens_q, min_ones_q);
               {min_tens_d, min_ones_d} = min_r[6:0];
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Blink phase: restarts on every mode change, runs on scan ticks while setting.
   always_comb begin
      blink_d = blink_q;
      bcnt_d  = bcnt_q;
      if (state_d != state_q || state_q == RUN || state_q == mode_t'(2'b11)) begin
         blink_d = 1'b0;
         bcnt_d  = '0;
      end else if (scan_tick) begin
         if (bcnt_q == BW'(BLINK_HALF - 1)) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
         end else begin
            bcnt_d = bcnt_q + BW'(1);
         end
      end
   end

   // State registers with synchronous reset taking priority over all events.
   always_ff @(posedge clk1) begin
      if (rst) begin
         state_q    <= RUN;
         c1hz_q     <= 1'b0;
         c500_q     <= 1'b0;
         stable_q   <= 2'b00;
         dcnt_q     <= '0;
         hr_tens_q  <= 2'd0;
         hr_ones_q  <= 4'd0;
         min_tens_q <= 3'd0;
         min_ones_q <= 4'd0;
         sec_tens_q <= 3'd0;
         sec_ones_q <= 4'd0;
         blink_q    <= 1'b0;
         bcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         c1hz_q     <= c1hz_d;
         c500_q     <= c500_d;
         stable_q   <= stable_d;
         dcnt_q     <= dcnt_d;
         hr_tens_q  <= hr_tens_d;
         hr_ones_q  <= hr_ones_d;
         min_tens_q <= min_tens_d;
         min_ones_q <= min_ones_d;
         sec_tens_q <= sec_tens_d;
         sec_ones_q <= sec_ones_d;
         blink_q    <= blink_d;
         bcnt_q     <= bcnt_d;
      end
   end

   assign hr_tens  = hr_tens_q;
   assign hr_ones  = hr_ones_q;
   assign min_tens = min_tens_q;
   assign min_ones = min_ones_q;
   assign sec_tens = sec_tens_q;
   assign sec_ones = sec_ones_q;
   assign mode     = state_q;
   assign blink    = blink_q;

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
Timekeeping and time-set controller for the 24-hour digital clock, clocked by the board clock clk1. It consumes the divider's clk_1hz and clk_500hz levels as sampled signals, not as clocks, and turns them into single-cycle enables. It keeps BCD hours, minutes and seconds, and runs a mode FSM that lets the user set hours and minutes with two debounced buttons. Outputs feed the display multiplexer.

Parameters:
DEBOUNCE_SAMPLES, 4, consecutive equal scan-tick samples needed to accept a new button level (range 2..15)
BLINK_HALF, 125, scan ticks per blink half-period (125 gives a 2 Hz blink)

Ports:
clk1  input  1  system clock, single clock domain
rst  input  1  synchronous, active-high reset
clk_1hz  input  1  1 Hz square level from the divider
clk_500hz  input  1  500 Hz square level from the divider
btn_mode  input  1  raw mode pushbutton, active-high, already synchronised
btn_inc  input  1  raw increment pushbutton, active-high, already synchronised
hr_tens  output  2  BCD hours tens (0..2)
hr_ones  output  4  BCD hours ones
min_tens  output  3  BCD minutes tens (0..5)
min_ones  output  4  BCD minutes ones
sec_tens  output  3  BCD seconds tens (0..5)
sec_ones  output  4  BCD seconds ones
mode  output  2  00 RUN, 01 SET_HR, 10 SET_MIN
blink  output  1  digit-blank request for the field being set

Behaviour:
- Reset, sampled on the clk1 rising edge with rst=1:
  - all time digits 0, mode=RUN, blink=0
  - edge-detect registers, debounce counters and stable levels 0, blink counter 0
  - rst has priority over every other event, including mid-count and mid-set.
- Tick generation:
  - tick_1hz = clk_1hz & ~clk_1hz_d; scan_tick = clk_500hz & ~clk_500hz_d.
  - Each is exactly one clk1 cycle wide.
  - Registers act on the same edge where the 1 is first sampled after a 0.
- Debounce, per button:
  - Evaluated only on scan_tick.
  - Sample differs from the stable level: counter increments. Sample equals it: counter clears.
  - When the counter reaches DEBOUNCE_SAMPLES, the stable level flips and the counter clears.
  - A 0->1 stable flip produces a one-cycle press pulse. Release produces no pulse.
- FSM:
  - RUN --mode press--> SET_HR --mode press--> SET_MIN --mode press--> RUN.
  - Code 11 is unreachable. If it is ever decoded, go to RUN.
- RUN:
  - On tick_1hz, seconds increment with BCD carry: 59 s -> 00 plus minute carry, 59 min -> 00 plus hour carry, 23:59:59 -> 00:00:00.
  - inc presses are ignored.
- SET_HR:
  - tick_1hz is ignored and time is frozen.
  - inc press: hours +1, with 09->10, 19->20, 23->00. Minutes and seconds are unchanged.
- SET_MIN:
  - tick_1hz is ignored.
  - inc press: minutes +1, 59->00, no carry into hours.
- Leaving SET_MIN for RUN: seconds are cleared to 00 on that edge. A tick_1hz in that same cycle is discarded.
- A mode press and an inc press in the same cycle: mode wins and the inc press is discarded.
- Blink:
  - 0 in RUN.
  - On any mode transition, blink=0 and the counter clears.
  - In SET states, the counter increments on scan_tick. When it reaches BLINK_HALF-1 it clears and blink toggles.
- All outputs are registered, with no combinational path from inputs to outputs.
- BCD digits never leave their legal ranges. Illegal combinations cannot be produced by any input sequence.

Test Plan:
- Reset: apply rst for 3 cycles, then toggle clk_1hz -> 00:00:00, mode=00, blink=0. After one clk_1hz rising edge -> 00:00:01, with exactly one increment per rising edge.
- Rollover: preload 23:59:58 via the set flow, then give two 1 Hz edges -> 23:59:59, then 00:00:00, with no intermediate illegal digit.
- Hour set: press mode once (mode=01), press inc 24 times from 00 -> 01..23, then 00. Minutes stay unchanged. Seconds stay frozen across 1 Hz edges.
- Debounce (DEBOUNCE_SAMPLES=4):
  - btn_inc high for 3 scan ticks, then low -> no press.
  - btn_inc high for 4 scan ticks -> exactly one press pulse, minute +1 in SET_MIN.
  - Release produces no pulse.
- Simultaneous events:
  - In SET_MIN with seconds nonzero, mode and inc press pulses in the same cycle, coinciding with tick_1hz -> mode=00, seconds=00, minutes unchanged.
  - On the next 1 Hz edge -> seconds=01.
- Mid-operation reset: in SET_HR with blink=1, assert rst for 1 cycle -> mode=00, blink=0, time 00:00:00, and no press is generated from a held button until a new 4-sample stable level is seen.
